// File: rtl/rnm_clk_gen.sv
// Real-number-model square-wave oscillator: programmable amplitude code and period,
// with edge strobes, a rising-edge counter and optional slew-limited level output.
module rnm_clk_gen #(
  parameter int unsigned AMP_W = 16,
  parameter int unsigned PER_W = 32,
  parameter int unsigned SLEW  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AMP_W-1:0] amp,
  input  logic [PER_W-1:0] period,
  output logic             clk_out,
  output logic [AMP_W-1:0] vout,
  output logic             rise,
  output logic             fall,
  output logic [31:0]      cyc_cnt
);

  localparam int unsigned CNT_W = 32;

  logic [PER_W-1:0] ph, ph_nxt;
  logic [PER_W-1:0] per_l, per_l_nxt, per_sel;
  logic [AMP_W-1:0] amp_l, amp_l_nxt, amp_sel;
  logic [PER_W:0]   p_eff, hi_len;
  logic             start, clk_nxt, rise_nxt, fall_nxt;
  logic [AMP_W-1:0] tgt, diff, step, vout_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next-state: phase advance, period-start latching, level target and slew
  always_comb begin
    ph_nxt    = ph;
    per_l_nxt = per_l;
    amp_l_nxt = amp_l;
    clk_nxt   = 1'b0;
    diff      = '0;
    step      = '0;
    vout_nxt  = vout;

    // At ph = 0 the freshly sampled inputs govern the period that is starting
    start   = (ph == '0);
    per_sel = start ? period : per_l;
    amp_sel = start ? amp : amp_l;
    p_eff   = (per_sel < PER_W'(2)) ? (PER_W+1)'(2) : {1'b0, per_sel};
    hi_len  = (p_eff + (PER_W+1)'(1)) >> 1;

    if (en) begin
      if (start) begin
        per_l_nxt = period;
        amp_l_nxt = amp;
      end
      clk_nxt = ({1'b0, ph} < hi_len);
      ph_nxt  = ({1'b0, ph} == p_eff - (PER_W+1)'(1)) ? '0 : ph + PER_W'(1);
    end else begin
      ph_nxt = '0;
    end

    tgt = clk_nxt ? amp_sel : '0;

    if (SLEW == 0) begin
      vout_nxt = tgt;
    end else if (tgt > vout) begin
      diff     = tgt - vout;
      step     = (32'(diff) > SLEW) ? AMP_W'(SLEW) : diff;
      vout_nxt = vout + step;
    end else begin
      diff     = vout - tgt;
      step     = (32'(diff) > SLEW) ? AMP_W'(SLEW) : diff;
      vout_nxt = vout - step;
    end

    rise_nxt = clk_nxt & ~clk_out;
    fall_nxt = ~clk_nxt & clk_out;
    cnt_nxt  = cyc_cnt + CNT_W'(rise_nxt);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph      <= '0;
      per_l   <= '0;
      amp_l   <= '0;
      clk_out <= 1'b0;
      vout    <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      ph      <= ph_nxt;
      per_l   <= per_l_nxt;
      amp_l   <= amp_l_nxt;
      clk_out <= clk_nxt;
      vout    <= vout_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      cyc_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rnm_clk_gen.sv
// Bench for rnm_clk_gen: an instant-step and a slewed instance driven in parallel,
// checked every cycle against a period/phase arithmetic model plus directed checks.
module tb_rnm_clk_gen;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [15:0] amp;
  logic [31:0] period;

  logic        clk0, rise0, fall0, clk1, rise1, fall1;
  logic [15:0] vout0, vout1;
  logic [31:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rnm_clk_gen #(.AMP_W(16), .PER_W(32), .SLEW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .amp(amp), .period(period),
    .clk_out(clk0), .vout(vout0), .rise(rise0), .fall(fall0), .cyc_cnt(cnt0)
  );

  rnm_clk_gen #(.AMP_W(16), .PER_W(32), .SLEW(1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .amp(amp), .period(period),
    .clk_out(clk1), .vout(vout1), .rise(rise1), .fall(fall1), .cyc_cnt(cnt1)
  );

  // Reference model: position within the current period plus latched settings
  longint m_pos, m_P, m_amp, m_cnt, m_v0, m_v1;
  bit     m_clk, m_rise, m_fall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint tgt, d;
    bit nclk;
    if (!rst_n) begin
      m_pos = 0; m_P = 0; m_amp = 0; m_cnt = 0; m_v0 = 0; m_v1 = 0;
      m_clk = 0; m_rise = 0; m_fall = 0;
      return;
    end
    nclk = 0;
    if (en) begin
      if (m_pos == 0) begin
        m_P   = (period < 2) ? 2 : longint'(period);
        m_amp = longint'(amp);
      end
      nclk  = (m_pos < (m_P + 1) / 2);
      m_pos = (m_pos + 1) % m_P;
    end else begin
      m_pos = 0;
    end
    m_rise = nclk && !m_clk;
    m_fall = !nclk && m_clk;
    if (m_rise) m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
    m_clk = nclk;
    tgt   = nclk ? m_amp : 0;
    m_v0  = tgt;
    d = tgt - m_v1;
    if (d > 1000)  d = 1000;
    if (d < -1000) d = -1000;
    m_v1 = m_v1 + d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("clk_out0", 64'(clk0), 64'(m_clk));
    chk("rise0",    64'(rise0), 64'(m_rise));
    chk("fall0",    64'(fall0), 64'(m_fall));
    chk("vout0",    64'(vout0), 64'(m_v0));
    chk("cyc_cnt0", 64'(cnt0),  64'(m_cnt));
    chk("clk_out1", 64'(clk1),  64'(m_clk));
    chk("rise1",    64'(rise1), 64'(m_rise));
    chk("fall1",    64'(fall1), 64'(m_fall));
    chk("vout1",    64'(vout1), 64'(m_v1));
    chk("cyc_cnt1", 64'(cnt1),  64'(m_cnt));
  endtask

  // Tick until the next rise; n = cycles taken, hi = high cycles strictly between rises
  task automatic run_until_rise(input int maxc, output int n, output int hi);
    n  = 0;
    hi = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      n++;
      if (rise0 === 1'b1) return;
      if (clk0 === 1'b1) hi++;
    end
    chk("rise_timeout", 64'(rise0), 64'd1);
  endtask

  initial begin
    int n, hi, saved, vmax;

    // Reset held with en high: everything stays zero
    rst_n = 1'b0; en = 1'b1; amp = 16'd5000; period = 32'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_clk", 64'(clk0), 64'd0);
      chk("rst_vout", 64'(vout0), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("first_rise", 64'(rise0), 64'd1);
    chk("first_vout", 64'(vout0), 64'd5000);
    for (int i = 0; i < 3; i++) begin
      run_until_rise(50, n, hi);
      chk("p10_spacing", 64'(n), 64'd10);
      chk("p10_high", 64'(hi + 1), 64'd5);
    end
    chk("cnt_after_4", 64'(cnt0), 64'd4);

    // Mid-period reprogramming at ph = 3
    en = 1'b0; tick();
    en = 1'b1; tick(); tick(); tick();
    period = 32'd4; amp = 16'd1000;
    run_until_rise(50, n, hi);
    chk("reprog_rest", 64'(n), 64'd8);
    chk("reprog_amp", 64'(vout0), 64'd1000);
    run_until_rise(50, n, hi);
    chk("reprog_p4", 64'(n), 64'd4);

    // Disable while high, then re-enable
    period = 32'd10; amp = 16'd5000;
    run_until_rise(50, n, hi);
    saved = int'(cnt0);
    en = 1'b0; tick();
    chk("dis_clk", 64'(clk0), 64'd0);
    chk("dis_fall", 64'(fall0), 64'd1);
    chk("dis_vout", 64'(vout0), 64'd0);
    chk("dis_cnt", 64'(cnt0), 64'(saved));
    en = 1'b1; tick();
    chk("reen_rise", 64'(rise0), 64'd1);

    // Odd and degenerate periods
    period = 32'd3;
    run_until_rise(50, n, hi);
    run_until_rise(50, n, hi);
    chk("p3_spacing", 64'(n), 64'd3);
    chk("p3_high", 64'(hi + 1), 64'd2);
    for (int p = 0; p < 2; p++) begin
      period = 32'(p);
      run_until_rise(50, n, hi);
      run_until_rise(50, n, hi);
      chk("pdeg_spacing", 64'(n), 64'd2);
      chk("pdeg_high", 64'(hi + 1), 64'd1);
    end

    // Slew: full ramp at period 20
    en = 1'b0; period = 32'd20; amp = 16'd5000;
    for (int i = 0; i < 8; i++) tick();
    en = 1'b1; tick();
    chk("slew_1st", 64'(vout1), 64'd1000);
    for (int i = 0; i < 4; i++) tick();
    chk("slew_top", 64'(vout1), 64'd5000);

    // Slew: period 6 reverses at 3000
    en = 1'b0; period = 32'd6;
    for (int i = 0; i < 8; i++) tick();
    en = 1'b1; vmax = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (int'(vout1) > vmax) vmax = int'(vout1);
    end
    chk("slew_peak", 64'(vmax), 64'd3000);

    // Nominal: amp 5000, period 30000
    period = 32'd30000; amp = 16'd5000;
    run_until_rise(100, n, hi);
    run_until_rise(40000, n, hi);
    chk("nom_spacing", 64'(n), 64'd30000);
    chk("nom_high", 64'(hi + 1), 64'd15000);

    // Randomized inputs against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) period = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) amp = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rnm_clk_gen.md
Name: rnm_clk_gen

Overview:
- Real-number-model (RNM) periodic clock source: produces a square wave whose high level is a programmable amplitude code and whose period is programmable in clock cycles.
- Used in mixed-signal DUT models (e.g. VCO/PLL models) as a stand-in oscillator. Example use: amplitude 5.0 V, period 30000.
- Drives a digital clock bit, a multi-bit level output (the RNM "voltage"), edge strobes and a rising-edge counter.

Parameters:
- AMP_W, 16, width of amplitude/level codes (unsigned, 1 LSB = 1 mV; 5000 = 5.0 V).
- PER_W, 32, width of the period input (units: clk cycles).
- SLEW, 0, maximum change of vout per cycle in LSBs; 0 = instantaneous step.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run enable.
- amp  in  AMP_W  high-level amplitude code.
- period  in  PER_W  oscillation period in clk cycles.
- clk_out  out  1  generated square wave.
- vout  out  AMP_W  RNM level: amp while high, 0 while low, optionally slew-limited.
- rise  out  1  one-cycle strobe in the first cycle clk_out = 1.
- fall  out  1  one-cycle strobe in the first cycle clk_out = 0 after being 1.
- cyc_cnt  out  32  count of rising edges, wraps 2^32-1 -> 0.

Behaviour:
- Reset (rst_n = 0 at a clk edge): clk_out = 0, vout = 0, rise = 0, fall = 0, cyc_cnt = 0, phase counter ph = 0, latched period and amplitude = 0. Reset takes priority over all other inputs.
- Latching:
  - amp and period are sampled into shadow registers only when ph = 0 with en = 1, i.e. at the start of each period.
  - Changes to amp or period mid-period take effect at the next period start; there are no glitches.
- Effective period: P = max(period_latched, 2).
  - High phase = ceil(P/2) cycles; low phase = floor(P/2) cycles.
  - Example: P = 3 gives 2 cycles high, 1 cycle low.
  - Period 0 or 1 is treated as 2.
- Phase counter: while en = 1, ph increments each cycle and wraps from P-1 to 0. All outputs are registered.
  - clk_out = 1 for ph in [0, ceil(P/2)-1]; clk_out = 0 otherwise.
  - On the first cycle after en is sampled high from idle, clk_out goes to 1 (ph = 0) and rise = 1.
- Strobes and counter:
  - rise is asserted exactly in the cycle clk_out transitions 0 -> 1.
  - fall is asserted exactly in the cycle clk_out transitions 1 -> 0.
  - rise and fall are never asserted together.
  - cyc_cnt increments in the same cycle rise asserts.
- Disable:
  - en = 0 forces ph = 0 and clk_out = 0 on the next edge.
  - fall pulses if clk_out was 1; the vout target becomes 0.
  - Re-enable restarts at phase 0 with fresh latching.
  - cyc_cnt is held, not cleared.
- vout target: latched amp while clk_out (next state) = 1, otherwise 0.
  - SLEW = 0: vout equals the target in the same cycle as clk_out.
  - SLEW > 0: vout moves toward the target by min(SLEW, |target - vout|) per cycle. It saturates at the target and never overshoots or wraps.
  - If the period is shorter than the ramp, vout reverses direction mid-ramp without discontinuity.
- amp = 0: clk_out and strobes still toggle; vout stays 0.
- Latency: en high to first rise = 1 cycle. Period boundaries are exact: rising edges are P cycles apart, with no drift.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with en = 1, amp = 5000, period = 10 -> all outputs 0 throughout; after release, first rise 1 cycle later and vout = 5000.
- Nominal: amp = 5000, period = 30000, SLEW = 0 -> clk_out high 15000 / low 15000 cycles, rise spacing exactly 30000, vout in {0, 5000}, cyc_cnt = 4 after 4 rises.
- Odd/degenerate period:
  - period = 3 -> high 2, low 1.
  - period = 0 or 1 -> behaves as 2 (alternating every cycle, rise every 2 cycles).
- Mid-period reprogramming: change period 10 -> 4 and amp 5000 -> 1000 at ph = 3 -> current period completes as 10 cycles at 5000; next period is 4 cycles at 1000.
- Disable/re-enable: drop en while clk_out = 1 -> next cycle clk_out = 0, fall = 1, vout -> 0, cyc_cnt held; raise en -> rise 1 cycle later with ph = 0.
- Slew: SLEW = 1000, amp = 5000, period = 20 -> vout ramps 1000, 2000, ..., 5000 over 5 cycles after rise, then 5000 -> 0 in 5 steps after fall; with period = 6, vout peaks at 3000 and reverses without overshoot.
